mr1_mem_arbiter: RTL and testbench

// - Shares one memory port between the MR1 instruction-fetch and data (load/store) requesters.
// - Fixed-priority arbitration favours data, with a starvation guard for fetch.
// - Tracks outstanding reads in order and routes each read response back to its requester.
// - Sits between the MR1 core and the single-ported memory/bus.

---
 rtl/mr1_mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mr1_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mr1_mem_arbiter.sv
// ============================================================================
// Module   : mr1_mem_arbiter
// Brief    : Shares one memory port between MR1 fetch and load/store, with a
//            fetch starvation guard and in-order read-response routing.
//            Optional perf counters: define MR1_MEM_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mr1_mem_arbiter #(
    parameter int MAX_OUTST    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_req_valid,
    output logic        instr_req_ready,
    input  logic [31:0] instr_req_addr,
    output logic        instr_rsp_valid,
    output logic [31:0] instr_rsp_data,
    input  logic        data_req_valid,
    output logic        data_req_ready,
    input  logic        data_req_wr,
    input  logic [31:0] data_req_addr,
    input  logic [31:0] data_req_wdata,
    input  logic [3:0]  data_req_be,
    output logic        data_rsp_valid,
    output logic [31:0] data_rsp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wr,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_be,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        rsp_err,
    output logic [31:0] perf_instr_cnt,
    output logic [31:0] perf_rd_cnt,
    output logic [31:0] perf_wr_cnt,
    output logic [31:0] perf_stall_cnt
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_MAX_OUTST    = CNT_W'(MAX_OUTST);
    localparam logic [STV_W-1:0] C_STARVE_LIMIT = STV_W'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_lock_data;
    logic [CNT_W-1:0]     r_fifo_cnt;
    logic [MAX_OUTST-1:0] r_src;
    logic [STV_W-1:0]     r_starve_cnt;
    logic                 r_rsp_err;

    logic                 w_slot_ok;
    logic                 w_instr_elig;
    logic                 w_data_elig;
    logic                 w_fetch_forced;
    logic                 w_sel_data;
    logic                 w_gnt_valid;
    logic                 w_mem_valid;
    logic                 w_xfer;
    logic                 w_instr_xfer;
    logic                 w_data_xfer;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_spurious;
    logic [CNT_W-1:0]     w_wr_idx;
    logic [MAX_OUTST-1:0] w_src_next;

    // Slot check uses the pre-pop count, so a same-cycle response never frees a slot early.
    assign w_slot_ok      = (r_fifo_cnt < C_MAX_OUTST);
    assign w_instr_elig   = instr_req_valid && w_slot_ok;
    assign w_data_elig    = data_req_valid && (data_req_wr || w_slot_ok);
    assign w_fetch_forced = w_instr_elig && (r_starve_cnt == C_STARVE_LIMIT);

    always_comb begin
        w_sel_data  = 1'b0;
        w_gnt_valid = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_sel_data  = r_lock_data;
            w_gnt_valid = r_lock_data ? data_req_valid : instr_req_valid;
        end else if (w_data_elig && !w_fetch_forced) begin
            w_sel_data  = 1'b1;
            w_gnt_valid = 1'b1;
        end else if (w_instr_elig) begin
            w_sel_data  = 1'b0;
            w_gnt_valid = 1'b1;
        end
    end

    assign w_mem_valid     = reset_n && w_gnt_valid;
    assign mem_req_valid   = w_mem_valid;
    assign mem_req_wr      = w_mem_valid && w_sel_data && data_req_wr;
    assign mem_req_addr    = !w_mem_valid ? 32'd0 : (w_sel_data ? data_req_addr : instr_req_addr);
    assign mem_req_wdata   = (w_mem_valid && w_sel_data) ? data_req_wdata : 32'd0;
    assign mem_req_be      = (w_mem_valid && w_sel_data) ? data_req_be : 4'd0;
    assign instr_req_ready = w_mem_valid && !w_sel_data && mem_req_ready;
    assign data_req_ready  = w_mem_valid && w_sel_data && mem_req_ready;

    assign w_xfer       = w_mem_valid && mem_req_ready;
    assign w_instr_xfer = w_xfer && !w_sel_data;
    assign w_data_xfer  = w_xfer && w_sel_data;
    assign w_push       = w_instr_xfer || (w_data_xfer && !data_req_wr);
    assign w_pop        = reset_n && mem_rsp_valid && (r_fifo_cnt != '0);
    assign w_spurious   = mem_rsp_valid && (r_fifo_cnt == '0);

    // Source FIFO as a shift register: entry 0 is the oldest outstanding read.
    always_comb begin
        w_src_next = w_pop ? (r_src >> 1) : r_src;
        w_wr_idx   = r_fifo_cnt - CNT_W'(w_pop);
        if (w_push) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                if (w_wr_idx == CNT_W'(i)) begin
                    w_src_next[i] = w_sel_data;
                end
            end
        end
    end

    assign instr_rsp_valid = w_pop && !r_src[0];
    assign data_rsp_valid  = w_pop && r_src[0];
    assign instr_rsp_data  = instr_rsp_valid ? mem_rsp_data : 32'd0;
    assign data_rsp_data   = data_rsp_valid ? mem_rsp_data : 32'd0;
    assign rsp_err         = r_rsp_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_lock_data <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_valid && !mem_req_ready) begin
                        r_state     <= ST_LOCKED;
                        r_lock_data <= w_sel_data;
                    end
                end
                ST_LOCKED: begin
                    if (w_xfer || !w_mem_valid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fifo_cnt   <= '0;
            r_src        <= '0;
            r_starve_cnt <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_src <= w_src_next;
            if (w_push && !w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_fifo_cnt <= r_fifo_cnt - 1'b1;
            end
            if (!instr_req_valid || w_instr_xfer) begin
                r_starve_cnt <= '0;
            end else if (w_data_xfer && (r_starve_cnt != C_STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            if (w_spurious) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

`ifdef MR1_MEM_ARB_PERF_EN
    logic [31:0] r_perf_instr;
    logic [31:0] r_perf_rd;
    logic [31:0] r_perf_wr;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_instr <= '0;
            r_perf_rd    <= '0;
            r_perf_wr    <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_instr_xfer)                  r_perf_instr <= r_perf_instr + 32'd1;
            if (w_data_xfer && !data_req_wr)   r_perf_rd    <= r_perf_rd + 32'd1;
            if (w_data_xfer && data_req_wr)    r_perf_wr    <= r_perf_wr + 32'd1;
            if (w_mem_valid && !mem_req_ready) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_instr_cnt = r_perf_instr;
    assign perf_rd_cnt    = r_perf_rd;
    assign perf_wr_cnt    = r_perf_wr;
    assign perf_stall_cnt = r_perf_stall;
`else
    assign perf_instr_cnt = 32'd0;
    assign perf_rd_cnt    = 32'd0;
    assign perf_wr_cnt    = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mr1_mem_arbiter.sv
// ============================================================================
// Module   : tb_mr1_mem_arbiter
// Brief    : Directed self-checking bench for mr1_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mr1_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_req_valid, instr_req_ready, instr_rsp_valid;
    logic [31:0] instr_req_addr, instr_rsp_data;
    logic        data_req_valid, data_req_ready, data_req_wr, data_rsp_valid;
    logic [31:0] data_req_addr, data_req_wdata, data_rsp_data;
    logic [3:0]  data_req_be;
    logic        mem_req_valid, mem_req_ready, mem_req_wr, mem_rsp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
    logic [3:0]  mem_req_be;
    logic        rsp_err;
    logic [31:0] perf_instr_cnt, perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;

    int checks   = 0;
    int failures = 0;

`ifdef MR1_MEM_ARB_PERF_EN
    localparam logic [31:0] C_EXP_INSTR = 32'd5;
    localparam logic [31:0] C_EXP_RD    = 32'd2;
    localparam logic [31:0] C_EXP_WR    = 32'd10;
    localparam logic [31:0] C_EXP_STALL = 32'd3;
`else
    localparam logic [31:0] C_EXP_INSTR = 32'd0;
    localparam logic [31:0] C_EXP_RD    = 32'd0;
    localparam logic [31:0] C_EXP_WR    = 32'd0;
    localparam logic [31:0] C_EXP_STALL = 32'd0;
`endif

    always #5 clk = ~clk;

    mr1_mem_arbiter #(.MAX_OUTST(2), .STARVE_LIMIT(4)) u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .instr_req_valid (instr_req_valid),
        .instr_req_ready (instr_req_ready),
        .instr_req_addr  (instr_req_addr),
        .instr_rsp_valid (instr_rsp_valid),
        .instr_rsp_data  (instr_rsp_data),
        .data_req_valid  (data_req_valid),
        .data_req_ready  (data_req_ready),
        .data_req_wr     (data_req_wr),
        .data_req_addr   (data_req_addr),
        .data_req_wdata  (data_req_wdata),
        .data_req_be     (data_req_be),
        .data_rsp_valid  (data_rsp_valid),
        .data_rsp_data   (data_rsp_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_wr      (mem_req_wr),
        .mem_req_addr    (mem_req_addr),
        .mem_req_wdata   (mem_req_wdata),
        .mem_req_be      (mem_req_be),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .rsp_err         (rsp_err),
        .perf_instr_cnt  (perf_instr_cnt),
        .perf_rd_cnt     (perf_rd_cnt),
        .perf_wr_cnt     (perf_wr_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        instr_req_valid = 1'b0; instr_req_addr = 32'd0;
        data_req_valid  = 1'b0; data_req_wr    = 1'b0; data_req_addr = 32'd0;
        data_req_wdata  = 32'd0; data_req_be   = 4'd0;
        mem_req_ready   = 1'b0; mem_rsp_valid  = 1'b0; mem_rsp_data  = 32'd0;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        instr_req_valid = 1'b1; data_req_valid = 1'b1; data_req_wr = 1'b1; mem_req_ready = 1'b1;
        #2;
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_instr_ready", instr_req_ready, 0);
        chk("rst_data_ready", data_req_ready, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_perf_instr", perf_instr_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_inputs();
        mem_req_ready = 1'b1;

        // Both valid: data first, fetch next cycle
        instr_req_valid = 1'b1; instr_req_addr = 32'h40;
        data_req_valid = 1'b1; data_req_wr = 1'b1; data_req_addr = 32'h200;
        data_req_wdata = 32'h11223344; data_req_be = 4'hF;
        #1;
        chk("t1_data_ready", data_req_ready, 1);
        chk("t1_instr_ready", instr_req_ready, 0);
        chk("t1_addr", mem_req_addr, 32'h200);
        chk("t1_wr", mem_req_wr, 1);
        chk("t1_wdata", mem_req_wdata, 32'h11223344);
        tick();
        data_req_valid = 1'b0;
        #1;
        chk("t1_fetch_ready", instr_req_ready, 1);
        chk("t1_fetch_addr", mem_req_addr, 32'h40);
        chk("t1_fetch_wr", mem_req_wr, 0);
        tick();
        instr_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD0001;
        #1;
        chk("t1_irsp_valid", instr_rsp_valid, 1);
        chk("t1_irsp_data", instr_rsp_data, 32'hDEAD0001);
        chk("t1_drsp_valid", data_rsp_valid, 0);
        tick();
        mem_rsp_valid = 1'b0;

        // Starvation guard: 4 stores then one fetch, twice
        instr_req_valid = 1'b1; instr_req_addr = 32'h80;
        data_req_valid = 1'b1; data_req_wr = 1'b1; data_req_addr = 32'h500;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("t2_fetch_gnt%0d", i), instr_req_ready, (i == 4 || i == 9) ? 1 : 0);
            chk($sformatf("t2_data_gnt%0d", i), data_req_ready, (i == 4 || i == 9) ? 0 : 1);
            tick();
        end
        instr_req_valid = 1'b0; data_req_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111;
        #1;
        chk("t2_irsp0", instr_rsp_valid, 1);
        tick();
        mem_rsp_data = 32'h2222;
        #1;
        chk("t2_irsp1_data", instr_rsp_data, 32'h2222);
        tick();
        mem_rsp_valid = 1'b0;

        // Two loads fill the slots; fetch waits for the first response
        data_req_valid = 1'b1; data_req_wr = 1'b0; data_req_addr = 32'h100;
        instr_req_valid = 1'b1; instr_req_addr = 32'hC0;
        #1;
        chk("t3_ld0_ready", data_req_ready, 1);
        chk("t3_ld0_addr", mem_req_addr, 32'h100);
        chk("t3_ld0_wr", mem_req_wr, 0);
        tick();
        data_req_addr = 32'h104;
        #1;
        chk("t3_ld1_ready", data_req_ready, 1);
        chk("t3_ld1_addr", mem_req_addr, 32'h104);
        tick();
        data_req_valid = 1'b0;
        #1;
        chk("t3_full_valid", mem_req_valid, 0);
        chk("t3_full_fetch", instr_req_ready, 0);
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hAAAA;
        #1;
        chk("t3_rsp0_valid", data_rsp_valid, 1);
        chk("t3_rsp0_data", data_rsp_data, 32'hAAAA);
        chk("t3_rsp0_ivalid", instr_rsp_valid, 0);
        chk("t3_rsp0_fetch", instr_req_ready, 0);
        tick();
        mem_rsp_data = 32'hBBBB;
        #1;
        chk("t3_rsp1_valid", data_rsp_valid, 1);
        chk("t3_rsp1_data", data_rsp_data, 32'hBBBB);
        chk("t3_fetch_ready", instr_req_ready, 1);
        chk("t3_fetch_addr", mem_req_addr, 32'hC0);
        tick();
        instr_req_valid = 1'b0; mem_rsp_data = 32'hCCCC;
        #1;
        chk("t3_irsp_valid", instr_rsp_valid, 1);
        chk("t3_irsp_data", instr_rsp_data, 32'hCCCC);
        chk("t3_irsp_dvalid", data_rsp_valid, 0);
        tick();
        mem_rsp_valid = 1'b0;

        // Lock: fetch held for 3 stall cycles while data arrives
        mem_req_ready = 1'b0;
        instr_req_valid = 1'b1; instr_req_addr = 32'h300;
        #1;
        chk("t4_valid", mem_req_valid, 1);
        chk("t4_addr0", mem_req_addr, 32'h300);
        chk("t4_iready0", instr_req_ready, 0);
        tick();
        data_req_valid = 1'b1; data_req_wr = 1'b1; data_req_addr = 32'h400;
        data_req_wdata = 32'hCAFEF00D; data_req_be = 4'h3;
        #1;
        chk("t4_addr1", mem_req_addr, 32'h300);
        chk("t4_wr1", mem_req_wr, 0);
        chk("t4_dready1", data_req_ready, 0);
        tick();
        #1;
        chk("t4_addr2", mem_req_addr, 32'h300);
        tick();
        mem_req_ready = 1'b1;
        #1;
        chk("t4_iready3", instr_req_ready, 1);
        chk("t4_addr3", mem_req_addr, 32'h300);
        chk("t4_dready3", data_req_ready, 0);
        tick();
        instr_req_valid = 1'b0;
        #1;
        chk("t4_dready4", data_req_ready, 1);
        chk("t4_addr4", mem_req_addr, 32'h400);
        chk("t4_wdata4", mem_req_wdata, 32'hCAFEF00D);
        chk("t4_be4", {28'd0, mem_req_be}, 32'h3);
        tick();
        data_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h3003;
        #1;
        chk("t4_irsp_valid", instr_rsp_valid, 1);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("perf_instr", perf_instr_cnt, C_EXP_INSTR);
        chk("perf_rd", perf_rd_cnt, C_EXP_RD);
        chk("perf_wr", perf_wr_cnt, C_EXP_WR);
        chk("perf_stall", perf_stall_cnt, C_EXP_STALL);

        // Spurious response: dropped, sticky error until reset
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555;
        #1;
        chk("t5_ivalid", instr_rsp_valid, 0);
        chk("t5_dvalid", data_rsp_valid, 0);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("t5_err_set", rsp_err, 1);
        repeat (3) tick();
        chk("t5_err_sticky", rsp_err, 1);
        reset_n = 1'b0; instr_req_valid = 1'b1;
        #1;
        chk("t5_err_clr", rsp_err, 0);
        chk("t5_rst_valid", mem_req_valid, 0);
        chk("t5_rst_perf_wr", perf_wr_cnt, 0);
        chk("t5_rst_perf_stall", perf_stall_cnt, 0);
        tick();
        reset_n = 1'b1;
        clear_inputs();
        mem_req_ready = 1'b1;

        // Post-reset load round trip
        data_req_valid = 1'b1; data_req_wr = 1'b0; data_req_addr = 32'h600;
        #1;
        chk("t6_ld_ready", data_req_ready, 1);
        tick();
        data_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h6666;
        #1;
        chk("t6_rsp_valid", data_rsp_valid, 1);
        chk("t6_rsp_data", data_rsp_data, 32'h6666);
        chk("t6_err", rsp_err, 0);
        tick();
        mem_rsp_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
